// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder with programmable fetch latency and a program-load port
module imem_responder #(
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned LATENCY  = 2,
   parameter logic [31:0] NOP_WORD = 32'h00000013
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        rsp_err_o,
   input  logic        load_en_i,
   input  logic [31:0] load_addr_i,
   input  logic [31:0] load_data_i
);
   localparam int unsigned AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] data_q, data_d;
   logic        err_q, err_d;
   logic [31:0] mem_q [DEPTH];
   logic        req_err, load_ok;
   assign req_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:2] >= 30'(DEPTH));
   assign load_ok = load_en_i && (load_addr_i[1:0] == 2'b00) && (load_addr_i[31:2] < 30'(DEPTH));
   // program-load writes; a same-edge fetch read still sees the old word
   always_ff @(posedge clk_i) begin
      if (load_ok) mem_q[load_addr_i[AW+1:2]] <= load_data_i;
   end
   // state and response registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end
   // next state: capture the word on acceptance, count down, hold until handshake
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (req_valid_i) begin
            data_d  = req_err ? NOP_WORD : mem_q[req_addr_i[AW+1:2]];
            err_d   = req_err;
            cnt_d   = 4'(LATENCY - 1);
            state_d = (LATENCY > 1) ? WAIT : RESP;
         end
         WAIT: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? RESP : WAIT;
         end
         RESP: state_d = rsp_ready_i ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   // outputs depend only on registered state
   always_comb begin
      req_ready_o = state_q == IDLE;
      rsp_valid_o = state_q == RESP;
      rsp_data_o  = data_q;
      rsp_err_o   = err_q;
   end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized check of imem_responder against an array-based reference model
module tb_imem_responder;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned LAT   = 2;
   localparam logic [31:0] NOP   = 32'h00000013;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, rsp_ready = 1'b0, load_en = 1'b0;
   logic [31:0] req_addr = '0, load_addr = '0, load_data = '0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_data;
   logic        r1_valid = 1'b0;
   logic [31:0] r1_addr = '0;
   logic        r1_ready, r1_rvalid, r1_err;
   logic [31:0] r1_data;
   logic [31:0] ref_mem [DEPTH];
   int          errs = 0, checks = 0;

   always #5 clk = ~clk;

   imem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .NOP_WORD(NOP)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
      .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data));

   imem_responder #(.DEPTH(DEPTH), .LATENCY(1), .NOP_WORD(NOP)) u_lat1 (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(r1_valid), .req_ready_o(r1_ready), .req_addr_i(r1_addr),
      .rsp_valid_o(r1_rvalid), .rsp_ready_i(1'b1), .rsp_data_o(r1_data), .rsp_err_o(r1_err),
      .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic bad_addr(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
   endfunction

   // reference effect of a load strobe at one clock edge
   task automatic model_load(input logic [31:0] a, input logic [31:0] d);
      if (!bad_addr(a)) ref_mem[a >> 2] = d;
   endtask

   task automatic load_word(input logic [31:0] a, input logic [31:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      tick();
      load_en = 1'b0;
      model_load(a, d);
   endtask

   // one fetch: optional same-edge load, latency check, hold for 'hold' cycles with loads to the same word
   task automatic fetch(input logic [31:0] a, input int hold, input logic ld, input logic [31:0] ld_a, input logic [31:0] ld_d);
      logic [31:0] exp_d;
      logic        exp_e;
      int          k;
      exp_e = bad_addr(a);
      exp_d = exp_e ? NOP : ref_mem[a >> 2];
      chk("idle_ready", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_addr = a; rsp_ready = 1'($urandom % 2);
      load_en = ld; load_addr = ld_a; load_data = ld_d;
      tick();
      req_valid = 1'b0; rsp_ready = 1'b0; load_en = 1'b0;
      if (ld) model_load(ld_a, ld_d);
      k = 0;
      while (!rsp_valid && k < 20) begin
         chk("wait_ready", {31'b0, req_ready}, 32'd0);
         tick();
         k++;
      end
      chk("latency", k, LAT - 1);
      for (int h = 0; h < hold; h++) begin
         chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
         chk("hold_ready", {31'b0, req_ready}, 32'd0);
         chk("hold_data", rsp_data, exp_d);
         load_word({a[31:2], 2'b00}, $urandom);
      end
      chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rsp_data", rsp_data, exp_d);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_e});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("post_valid", {31'b0, rsp_valid}, 32'd0);
      chk("post_ready", {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a, pend;
      int          k, i, hs;
      logic        acc;
      tick();
      tick();
      chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_err", {31'b0, rsp_err}, 32'd0);
      chk("rst_data", rsp_data, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      for (int w = 0; w < int'(DEPTH); w++) load_word(32'(4 * w), $urandom);
      // basic fetch with a long stall
      load_word(32'h0, 32'h00500093);
      fetch(32'h0, 5, 1'b0, '0, '0);
      // error cases and ignored loads
      fetch(32'h6, 1, 1'b0, '0, '0);
      fetch(32'(4 * DEPTH), 0, 1'b0, '0, '0);
      load_word(32'(4 * DEPTH + 4), 32'hBAD0BAD0);
      load_word(32'h5, 32'hBAD1BAD1);
      fetch(32'h4, 0, 1'b0, '0, '0);
      // same-edge load returns the old word, next fetch sees the new one
      fetch(32'h8, 0, 1'b1, 32'h8, 32'hDEADBEEF);
      fetch(32'h8, 0, 1'b0, '0, '0);
      // randomized fetches
      for (int n = 0; n < 40; n++) begin
         k = int'($urandom % 4);
         a = (k < 2) ? 32'(4 * ($urandom % DEPTH)) :
             (k == 2) ? (32'(4 * ($urandom % DEPTH)) | 32'(1 + $urandom % 3)) :
             ($urandom | 32'h8000_0000);
         fetch(a, int'($urandom % 3), 1'($urandom % 2), 32'(4 * ($urandom % (DEPTH + 2))), $urandom);
      end
      // reset during WAIT drops the response
      req_valid = 1'b1; req_addr = 32'h0;
      tick();
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rstw_valid", {31'b0, rsp_valid}, 32'd0);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("rstw_after", {31'b0, rsp_valid}, 32'd0);
      end
      chk("rstw_ready", {31'b0, req_ready}, 32'd1);
      // latency-1 instance: continuous requests, one response every two cycles
      i = 0; hs = 0; pend = '0;
      r1_valid = 1'b1; r1_addr = 32'h0;
      for (int t = 0; t < 10; t++) begin
         chk("l1_ready", {31'b0, r1_ready}, {31'b0, 1'(t % 2 == 0)});
         chk("l1_valid", {31'b0, r1_rvalid}, {31'b0, 1'(t % 2 == 1)});
         if (r1_rvalid) begin
            chk("l1_data", r1_data, pend);
            chk("l1_err", {31'b0, r1_err}, 32'd0);
            hs++;
         end
         acc = r1_ready;
         if (acc) pend = ref_mem[i];
         tick();
         if (acc) begin
            i++;
            r1_addr = 32'(4 * i);
         end
      end
      r1_valid = 1'b0;
      chk("l1_handshakes", hs, 5);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
